// File: rtl/dmem_pkg.sv
// Shared definitions for byte_data_memory: access-size encodings and lane-mask helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } dmem_size_e;

    // Bit i selects byte lane i; lane 0 holds the most significant byte of a word.
    function automatic logic [3:0] size_to_lane_mask(input logic [1:0] size,
                                                     input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = '0;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addr_lo;
            SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = '1;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: positions store data onto byte lanes and
// extracts/extends load data from a 32-bit bank word (big-endian lanes).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] wlane_data,
    output logic [3:0]  wlane_mask,
    input  logic [31:0] rword,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        sign_en;

    // Store data is replicated across lanes; the mask picks which lanes are written.
    always_comb begin
        wlane_mask = size_to_lane_mask(size, addr_lo);
        case (size)
            SZ_BYTE: wlane_data = {4{wdata[7:0]}};
            SZ_HALF: wlane_data = {2{wdata[15:0]}};
            default: wlane_data = wdata;
        endcase
    end

    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rword[31:24];
            2'd1:    rbyte = rword[23:16];
            2'd2:    rbyte = rword[15:8];
            default: rbyte = rword[7:0];
        endcase
        rhalf   = addr_lo[1] ? rword[15:0] : rword[31:16];
        sign_en = !is_unsigned;
        case (size)
            SZ_BYTE: rdata = {{24{sign_en & rbyte[7]}}, rbyte};
            SZ_HALF: rdata = {{16{sign_en & rhalf[15]}}, rhalf};
            SZ_WORD: rdata = rword;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed big-endian data memory with valid/ready request and registered response.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of ignoring low bits.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned OFF_W = $clog2(DEPTH_BYTES);
    localparam int unsigned IDX_W = OFF_W - 2;
    localparam int unsigned WORDS = DEPTH_BYTES / 4;

    logic [7:0]       bank_q [4][WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [31:0]      wlane_data;
    logic [3:0]       wlane_mask;
    logic [31:0]      load_rdata;
    logic             out_of_range;
    logic             misalign;
    logic             req_err;
    logic             accept;
    logic             we;

    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q,   resp_err_d;

    generate
        if (ADDR_W > OFF_W) begin : g_range
            always_comb out_of_range = |req_addr[ADDR_W-1:OFF_W];
        end else begin : g_norange
            always_comb out_of_range = 1'b0;
        end
    endgenerate

    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        idx       = req_addr[OFF_W-1:2];
        rword     = {bank_q[0][idx], bank_q[1][idx], bank_q[2][idx], bank_q[3][idx]};
        req_err   = out_of_range || (req_size == SZ_RSVD) || misalign;
        req_ready = rst_n && (!resp_valid_q || resp_ready);
        accept    = req_valid && req_ready;
        we        = accept && req_write && !req_err;
    end

    dmem_lane_align u_align (
        .size        (req_size),
        .addr_lo     (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .wlane_data  (wlane_data),
        .wlane_mask  (wlane_mask),
        .rword       (rword),
        .rdata       (load_rdata)
    );

    // Storage is not reset; only the addressed lanes are written.
    always_ff @(posedge clk) begin
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if (we && wlane_mask[lane]) begin
                bank_q[lane][idx] <= wlane_data[8*(3-lane) +: 8];
            end
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = req_err;
            resp_rdata_d = (req_write || req_err) ? '0 : load_rdata;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: byte-array reference model plus directed and random traffic.
module tb_byte_data_memory;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int          n_checks;
    int          n_fail;

    logic [7:0]  mem [DEPTH];
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    byte_data_memory #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain byte array, big-endian assembly, arithmetic extension.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic e);
        int unsigned n;
        int unsigned base;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (a >= DEPTH) || (sz == 2'd3);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((a % n) != 0) e = 1'b1;
`endif
        rd = '0;
        if (e) return;
        base = a - (a % n);
        if (w) begin
            for (int unsigned k = 0; k < n; k++)
                mem[base+k] = 8'(wd >> (8*(n-1-k)));
        end else begin
            v = '0;
            for (int unsigned k = 0; k < n; k++)
                v = (v << 8) | 32'(mem[base+k]);
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endtask

    // Single compare process: checks outputs, then advances the model for the coming edge.
    always @(negedge clk) begin
        logic mready;
        logic [31:0] rd;
        logic e;
        if (!rst_n) begin
            exp_valid = 1'b0;
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_req_ready", 32'(req_ready), 32'd0);
        end else begin
            mready = !exp_valid || resp_ready;
            check("req_ready", 32'(req_ready), 32'(mready));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
            end
            if (exp_valid && resp_ready) exp_valid = 1'b0;
            if (req_valid && mready) begin
                model_access(req_write, req_size, req_unsigned, req_addr, req_wdata, rd, e);
                exp_rdata = rd;
                exp_err   = e;
                exp_valid = 1'b1;
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e);
        bit ok;
        @(posedge clk); #1;
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int unsigned c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        rd = '0; e = 1'b1;
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        for (int unsigned c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (resp_valid) ok = 1'b1;
        end
        if (!ok) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        rd = resp_rdata;
        e  = resp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic e;
        n_checks = 0; n_fail = 0;
        exp_valid = 1'b0; exp_rdata = '0; exp_err = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        #23;
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        for (int unsigned i = 0; i < DEPTH; i += 4)
            do_req(1'b1, 2'd2, 1'b0, i, $urandom, rd, e);

        // Word round-trip
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, rd, e);
        check("t1_store_rdata", rd, 32'd0);
        check("t1_store_err", 32'(e), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, e);
        check("t1_load_word", rd, 32'h12345678);
        check("t1_load_err", 32'(e), 32'd0);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, rd, e);
        check("t1_load_byte_u", rd, 32'h00000012);

        // Sign extension
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'd0, rd, e);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h80, rd, e);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'd0, rd, e);
        check("t2_byte_s", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'd0, rd, e);
        check("t2_byte_u", rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, rd, e);
        check("t2_half_s_pos", rd, 32'h00000080);
        do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h180, rd, e);
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, rd, e);
        check("t2_half_s_neg", rd, 32'hFFFF8080);

        // Partial store
        do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'hAABBCCDD, rd, e);
        do_req(1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF1122, rd, e);
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, rd, e);
        check("t3_partial", rd, 32'hAABB1122);

        // Backpressure
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(negedge clk);
        check("t4_first_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_addr = 32'h30;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_blocked", 32'(req_ready), 32'd0);
            check("t4_hold_valid", 32'(resp_valid), 32'd1);
            check("t4_hold_rdata", resp_rdata, 32'h12345678);
            @(posedge clk);
        end
        #1 resp_ready = 1'b1;
        @(negedge clk);
        check("t4_second_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("t4_second_valid", 32'(resp_valid), 32'd1);
        check("t4_second_rdata", resp_rdata, 32'hAABB1122);

        // Errors
        do_req(1'b0, 2'd2, 1'b0, DEPTH, 32'd0, rd, e);
        check("t5_oor_err", 32'(e), 32'd1);
        check("t5_oor_rdata", rd, 32'd0);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, rd, e);
        check("t5_rsvd_err", 32'(e), 32'd1);
        do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'hDEADBEEF, rd, e);
        check("t5_rsvd_store_err", 32'(e), 32'd1);
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(1'b1, 2'd2, 1'b0, 32'h41, 32'h01020304, rd, e);
        check("t5_misalign_err", 32'(e), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd, e);
        check("t5_misalign_nowrite", rd, 32'hCAFEF00D);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h41, 32'd0, rd, e);
        check("t5_misalign_word", rd, 32'hCAFEF00D);
        check("t5_misalign_noerr", 32'(e), 32'd0);
`endif

        // Reset while a response is held
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h30; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("t6_held", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(resp_valid), 32'd0);
        check("t6_async_rdata", resp_rdata, 32'd0);
        check("t6_async_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1; resp_ready = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, e);
        check("t6_after_reset", rd, 32'h12345678);

        // Random traffic against the model
        for (int unsigned c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            req_valid    = ($urandom % 4) != 0;
            req_write    = $urandom % 2;
            req_size     = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
            req_unsigned = $urandom % 2;
            case ($urandom % 16)
                0:       req_addr = DEPTH + ($urandom % 64);
                1:       req_addr = $urandom;
                default: req_addr = $urandom % DEPTH;
            endcase
            req_wdata  = $urandom;
            resp_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
